// File: rtl/sa_pkg.sv
// Shared types and helpers for the SA stream decoder.
package sa_pkg;

    localparam int SA_N = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } sa_state_t;

    // Smallest r with 2^r >= v.
    function automatic int clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return int'(r);
    endfunction

    // ones * 2^(n-m), saturated to 2^n - 1. ones <= 2^m, so the product
    // never exceeds 2^n and fits easily in 32 bits.
    function automatic logic [31:0] sa_scale(input logic [31:0] ones,
                                             input int unsigned m,
                                             input int unsigned n);
        logic [31:0] shifted;
        logic [31:0] limit;
        shifted = ones << (n - m);
        limit   = 32'd1 << n;
        if (shifted >= limit) begin
            return limit - 32'd1;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/sa_stream_decoder_if.sv
// Bitstream input, frame control and result handshake of the decoder.
interface sa_stream_decoder_if #(
    parameter int N = sa_pkg::SA_N
);
    import sa_pkg::*;

    localparam int LW = clog2(N + 1);

    logic          start;
    logic [LW-1:0] len_log2;
    logic          bit_valid;
    logic          bit_in;
    logic [N-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic [N:0]    ones_cnt;
    logic          overrun;

    modport master (
        output start, len_log2, bit_valid, bit_in, dout_ready,
        input  dout, dout_valid, busy, ones_cnt, overrun
    );

    modport slave (
        input  start, len_log2, bit_valid, bit_in, dout_ready,
        output dout, dout_valid, busy, ones_cnt, overrun
    );

endinterface

// File: rtl/sa_frame_counter.sv
// Counts accepted bits and 1s of the current frame; flags the last bit.
module sa_frame_counter
    import sa_pkg::*;
#(
    parameter  int N  = SA_N,
    localparam int LW = clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic          i_bit,
    input  logic [LW-1:0] i_m,
    output logic [N:0]    o_ones,
    output logic [N:0]    o_ones_next,
    output logic          o_last
);

    logic [N:0] r_seen;
    logic [N:0] r_ones;
    logic [N:0] w_seen_next;
    logic [N:0] w_ones_inc;
    logic [N:0] w_frame_len;

    assign w_seen_next = r_seen + (N+1)'(1);
    assign w_ones_inc  = r_ones + (N+1)'(i_bit);
    assign w_frame_len = (N+1)'(1) << i_m;

    assign o_ones      = r_ones;
    assign o_ones_next = i_inc ? w_ones_inc : r_ones;
    assign o_last      = i_inc && (w_seen_next == w_frame_len);

    // Seen/ones registers: clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_seen <= '0;
            r_ones <= '0;
        end else if (i_inc) begin
            r_seen <= w_seen_next;
            r_ones <= w_ones_inc;
        end
    end

endmodule

// File: rtl/sa_stream_decoder.sv
// Stochastic bitstream decoder: counts 1s over 2^m bits, rescales to N bits.
module sa_stream_decoder
    import sa_pkg::*;
#(
    parameter int N = SA_N
) (
    input  logic                clk,
    input  logic                rst_n,
    sa_stream_decoder_if.slave  bus
);

    localparam int LW = clog2(N + 1);

    sa_state_t     r_state;
    sa_state_t     w_state_next;
    logic [LW-1:0] r_m;
    logic [N-1:0]  r_dout;
    logic          r_dout_valid;
    logic          r_overrun;

    logic          w_clr;
    logic          w_inc;
    logic          w_last;
    logic [N:0]    w_ones;
    logic [N:0]    w_ones_next;
    logic [LW-1:0] w_m_clamped;
    logic [N-1:0]  w_dout_next;

    // start is honoured only outside HOLD and always beats a same-cycle bit.
    assign w_clr = bus.start && (r_state != HOLD);
    assign w_inc = (r_state == RUN) && !bus.start && bus.bit_valid;

    assign w_m_clamped = (bus.len_log2 > LW'(N)) ? LW'(N) : bus.len_log2;
    assign w_dout_next = N'(sa_scale(32'(w_ones_next), 32'(r_m), N));

    sa_frame_counter #(
        .N (N)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_clr),
        .i_inc       (w_inc),
        .i_bit       (bus.bit_in),
        .i_m         (r_m),
        .o_ones      (w_ones),
        .o_ones_next (w_ones_next),
        .o_last      (w_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (bus.start) w_state_next = RUN;
            RUN:  if (!bus.start && w_last) w_state_next = HOLD;
            HOLD: if (r_dout_valid && bus.dout_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Frame length, result register, valid flag and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m          <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_clr) begin
                r_m <= w_m_clamped;
            end
            if (w_last) begin
                r_dout       <= w_dout_next;
                r_dout_valid <= 1'b1;
            end else if ((r_state == HOLD) && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end
            if (w_clr) begin
                r_overrun <= 1'b0;
            end else if ((r_state == HOLD) && bus.bit_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = (r_state != IDLE);
    assign bus.ones_cnt   = w_ones;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_sa_stream_decoder.sv
// Self-checking bench for sa_stream_decoder against a frame-level model.
module tb_sa_stream_decoder;
    import sa_pkg::*;

    localparam int N  = 7;
    localparam int LW = clog2(N + 1);
    localparam int FULL = 1 << N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sa_stream_decoder_if #(.N(N)) bus();

    sa_stream_decoder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame-level view of the decoder.
    bit collecting = 0;
    bit holding    = 0;
    int mdl_m      = 0;
    int mdl_ones   = 0;
    int mdl_seen   = 0;
    int mdl_dout   = 0;
    int mdl_dv     = 0;
    int mdl_ovr    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int v;
        if (!rst_n) begin
            collecting = 0; holding = 0;
            mdl_m = 0; mdl_ones = 0; mdl_seen = 0;
            mdl_dout = 0; mdl_dv = 0; mdl_ovr = 0;
        end else if (holding) begin
            if (bus.bit_valid) mdl_ovr = 1;
            if (bus.dout_ready) begin
                holding = 0;
                mdl_dv  = 0;
            end
        end else if (bus.start) begin
            mdl_m      = (int'(bus.len_log2) > N) ? N : int'(bus.len_log2);
            mdl_ones   = 0;
            mdl_seen   = 0;
            mdl_ovr    = 0;
            collecting = 1;
        end else if (collecting && bus.bit_valid) begin
            mdl_seen++;
            mdl_ones += int'(bus.bit_in);
            if (mdl_seen == (1 << mdl_m)) begin
                v = mdl_ones * (1 << (N - mdl_m));
                mdl_dout   = (v > FULL - 1) ? FULL - 1 : v;
                mdl_dv     = 1;
                collecting = 0;
                holding    = 1;
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic cyc(input logic st, input int len, input logic bv,
                       input logic bi, input logic rdy);
        bus.start      = st;
        bus.len_log2   = LW'(len);
        bus.bit_valid  = bv;
        bus.bit_in     = bi;
        bus.dout_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check("dout",       32'(bus.dout),       32'(mdl_dout));
        check("dout_valid", 32'(bus.dout_valid), 32'(mdl_dv));
        check("busy",       32'(bus.busy),       32'(collecting | holding));
        check("ones_cnt",   32'(bus.ones_cnt),   32'(mdl_ones));
        check("overrun",    32'(bus.overrun),    32'(mdl_ovr));
    endtask

    // Evenly spread bitstream with k ones per 128 bits.
    function automatic logic sa_bit(input int i, input int k);
        return logic'((((i + 1) * k) / 128) - ((i * k) / 128));
    endfunction

    initial begin
        logic [7:0] pat;
        logic [N-1:0] held;
        pat = 8'b0010_0010;

        bus.start = 0; bus.len_log2 = '0; bus.bit_valid = 0;
        bus.bit_in = 0; bus.dout_ready = 0;

        // Reset state
        rst_n = 0;
        cyc(0, 0, 1, 1, 0);
        cyc(1, 7, 1, 1, 0);
        check("reset_busy", 32'(bus.busy), 0);
        rst_n = 1;

        // Full frame, k=32
        cyc(1, 7, 0, 0, 0);
        for (int i = 0; i < 128; i++) begin
            cyc(0, 0, 1, sa_bit(i, 32), 0);
            if (i == 126) check("full_early_valid", 32'(bus.dout_valid), 0);
            if (i < 127) check("full_busy", 32'(bus.busy), 1);
        end
        check("full_dout", 32'(bus.dout), 32);
        check("full_valid", 32'(bus.dout_valid), 1);
        check("full_ones", 32'(bus.ones_cnt), 32);
        cyc(0, 0, 0, 0, 1);
        check("full_idle", 32'(bus.busy), 0);

        // Early termination m=3
        cyc(1, 3, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, pat[i], 0);
        check("m3_ones", 32'(bus.ones_cnt), 2);
        check("m3_dout", 32'(bus.dout), 32);
        cyc(0, 0, 0, 0, 1);

        // Saturation: m=0 single 1, and all-1s full frame
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        check("sat_m0_dout", 32'(bus.dout), 127);
        check("sat_m0_valid", 32'(bus.dout_valid), 1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 7, 0, 0, 0);
        for (int i = 0; i < 128; i++) cyc(0, 0, 1, 1, 0);
        check("sat_full_dout", 32'(bus.dout), 127);
        cyc(0, 0, 0, 0, 1);

        // Backpressure and overrun
        cyc(1, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, logic'($urandom_range(0, 1)), 0);
        held = bus.dout;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0);
        check("bp_dout_stable", 32'(bus.dout), 32'(held));
        check("bp_overrun", 32'(bus.overrun), 1);
        cyc(0, 0, 0, 0, 1);
        check("bp_release_valid", 32'(bus.dout_valid), 0);
        check("bp_release_busy", 32'(bus.busy), 0);
        cyc(1, 1, 0, 0, 0);
        check("bp_start_clears_ovr", 32'(bus.overrun), 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // Restart at bit 40 with a 1 presented in the start cycle
        cyc(1, 7, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0, 1, logic'($urandom_range(0, 1)), 0);
        cyc(1, 7, 1, 1, 0);
        check("restart_ones", 32'(bus.ones_cnt), 0);
        for (int i = 0; i < 127; i++) cyc(0, 0, 1, logic'($urandom_range(0, 1)), 0);
        check("restart_not_done", 32'(bus.dout_valid), 0);
        cyc(0, 0, 1, 0, 0);
        check("restart_done", 32'(bus.dout_valid), 1);

        // start during HOLD is ignored
        cyc(1, 3, 0, 0, 0);
        check("hold_start_valid", 32'(bus.dout_valid), 1);
        check("hold_start_busy", 32'(bus.busy), 1);
        cyc(0, 0, 0, 0, 1);

        // Reset mid-frame at bit 60
        cyc(1, 7, 0, 0, 0);
        for (int i = 0; i < 60; i++) cyc(0, 0, 1, 1, 0);
        rst_n = 0;
        cyc(0, 0, 1, 1, 0);
        rst_n = 1;
        check("rst_mid_busy", 32'(bus.busy), 0);
        check("rst_mid_ones", 32'(bus.ones_cnt), 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 0);
        check("rst_after_ones", 32'(bus.ones_cnt), 0);
        check("rst_after_ovr", 32'(bus.overrun), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cyc(logic'($urandom_range(0, 29) == 0),
                int'($urandom_range(0, 7)),
                logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 1)));
        end
        rst_n = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_stream_decoder.md
Name: sa_stream_decoder

Overview:
- Downstream consumer of the SA bitstream generator. Counts 1s in an SC bitstream over a programmable early-termination length of 2^m bits, m ≤ N.
- Rescales the count to an N-bit value estimate: value = ones · 2^(N−m).
- Presents the result on a valid/ready output handshake.
- Used to measure streaming accuracy at partial lengths and as the unary-to-binary back end of the decompressor path.

Parameters:
- N, 7, value bit width; full bitstream length L = 2^N.
- LW, clog2(N+1) (derived localparam, not overridable), width of len_log2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a new frame; latches len_log2 and clears the counters.
- len_log2  in  LW  frame length exponent m; the frame is 2^m bits. Values > N clamp to N.
- bit_valid  in  1  bit_in is valid this cycle (tie to the generator enable).
- bit_in  in  1  stochastic bit (generator x_out).
- dout  out  N  decoded value.
- dout_valid  out  1  dout holds a completed frame result.
- dout_ready  in  1  consumer accepts dout.
- busy  out  1  high in RUN or HOLD.
- ones_cnt  out  N+1  live 1s count of the current frame (debug).
- overrun  out  1  sticky flag: a bit_valid arrived while in HOLD. Cleared by start or reset.

Behaviour:
- Reset: all registers are synchronous to clk. When rst_n=0 at a clock edge:
  - state ← IDLE; dout, ones_cnt, seen counter, m_reg ← 0.
  - dout_valid, busy, overrun ← 0.
  - Reset overrides every other input, including mid-RUN or mid-HOLD. The partial frame is discarded.
- State machine:
  - IDLE. start=1 → m_reg ← min(len_log2, N); ones_cnt, seen ← 0; next state RUN. bit_valid in IDLE is ignored and does not set overrun.
  - RUN. Each cycle with bit_valid=1: seen += 1 and ones_cnt += bit_in. When the accepted bit makes seen == 2^m_reg:
    - dout ← sat(ones_cnt_next << (N − m_reg)), where ones_cnt_next includes this bit.
    - dout_valid ← 1; next state HOLD.
    - Latency: dout_valid rises on the edge after the last bit is sampled, i.e. visible 1 cycle after the final bit_valid.
  - RUN with start=1: restart. Clear the counters, re-latch len_log2, stay in RUN. A bit_valid in that same cycle is NOT counted (start wins).
  - HOLD. dout and dout_valid are stable until dout_valid & dout_ready. On that handshake: dout_valid ← 0, next state IDLE (dout keeps its last value).
  - HOLD with start=1: ignored. start is honoured only from IDLE or RUN.
  - HOLD with bit_valid=1: the bit is dropped and overrun ← 1.
- Arithmetic:
  - seen and ones_cnt are N+1 bits wide, so a count of 2^N is representable.
  - The shifted value is computed in N+1 bits. If it is ≥ 2^N, dout saturates to 2^N − 1. This happens e.g. for m=0 with bit 1, or for all-1s frames.
- m=0 gives a one-bit frame: dout_valid rises the cycle after the first valid bit.
- busy = (state ≠ IDLE).
- No combinational path from any input to any output.

Decomposition:
- Shared package sa_pkg:
  - state enum {IDLE, RUN, HOLD}.
  - default N.
  - function clog2.
  - function sa_scale(ones, m) returning the saturated N-bit value.
- One sub-module: sa_frame_counter.
  - Holds the seen and ones_cnt registers with clear/increment.
  - Outputs last = (seen_next == 2^m).
- The top level holds the FSM, the output register, and overrun.

Test Plan:
- Full frame, count 32: m=7; drive the bitstream of an SA generator with k=32 for 128 valid bits → exactly 32 ones, dout=32, dout_valid asserted 1 cycle after bit 128, busy=1 throughout.
- Early termination, count 2: m=3; drive pattern 0,1,0,0,0,1,0,0 (SA, k=32, 8 bits) → ones_cnt=2, dout = 2<<4 = 32.
- Saturation: m=0, single bit 1 → dout=127 (not 128). Also m=7 with 128 ones → dout=127.
- Backpressure / overrun: complete a frame with dout_ready=0 for 5 cycles and bit_valid=1 during HOLD → dout stable, overrun=1. On dout_ready=1 → dout_valid=0 next cycle and state IDLE. Next start → overrun=0.
- Restart and ignore rules:
  - start at bit 40 of an m=7 frame, with bit_valid=1 and bit_in=1 that cycle → that bit is not counted; the new frame needs 128 more bits.
  - start during HOLD → ignored; dout_valid stays 1.
- Reset mid-frame: rst_n=0 for 1 cycle at bit 60 → all outputs 0, state IDLE. Bits before the next start are ignored; overrun stays 0.
